// File: rtl/stopwatch_pkg.sv
// Shared constants and types for the stopwatch command sequencer.
package stopwatch_pkg;

    localparam logic [7:0] CMD_RUN   = 8'h52;  // 'R'
    localparam logic [7:0] CMD_CLR   = 8'h43;  // 'C'
    localparam logic [7:0] CMD_MODE  = 8'h4D;  // 'M'
    localparam logic [7:0] CMD_TIME  = 8'h54;  // 'T'
    localparam logic [7:0] ACK_UNK   = 8'h3F;  // '?'
    localparam logic [7:0] LC_OFFSET = 8'h20;

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CLEAR = 2'd2
    } sw_state_t;

    // Fold ASCII lowercase letters onto uppercase; everything else passes through.
    function automatic logic [7:0] to_upper(input logic [7:0] b);
        if (b >= 8'h61 && b <= 8'h7A)
            return b - LC_OFFSET;
        return b;
    endfunction

endpackage

// File: rtl/stopwatch_cmd_ctrl_if.sv
// UART-side bundle: received bytes in, echo bytes out.
interface stopwatch_cmd_ctrl_if;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       tx_busy;
    logic       tx_start;
    logic [7:0] tx_data;

    // UART / test side
    modport master (
        output rx_data, rx_done, tx_busy,
        input  tx_start, tx_data
    );

    // Command controller side
    modport slave (
        input  rx_data, rx_done, tx_busy,
        output tx_start, tx_data
    );
endinterface

// File: rtl/stopwatch_cmd_ctrl_ack_fifo.sv
// Small synchronous FIFO for echo bytes; pointers carry an extra wrap bit.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module ack_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    // Storage array, no reset needed: contents are only read when the FIFO is non-empty.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr[AW-1:0]] <= push_data;
    end

    // Read/write pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)
                rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

endmodule

// File: rtl/stopwatch_cmd_ctrl.sv
// Command sequencer: merges buttons and UART commands, runs the run/stop/clear
// FSM, emits mode/time toggle pulses and echoes each UART byte back.
//
//  state    | meaning
//  ST_STOP  | counter halted, waiting for run/stop or clear
//  ST_RUN   | counter enabled, only run/stop is honoured
//  ST_CLEAR | one-cycle clear pulse, all events ignored
module stopwatch_cmd_ctrl
    import stopwatch_pkg::*;
#(
    parameter int ACK_DEPTH    = 4,
    parameter bit ECHO_UNKNOWN = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 btn_runstop,
    input  logic                 btn_clear,
    stopwatch_cmd_ctrl_if.slave  uart,
    output logic                 run,
    output logic                 clear,
    output logic                 mode_toggle,
    output logic                 time_toggle,
    output logic [1:0]           state,
    output logic                 ack_ovf
);

    sw_state_t  state_q;
    sw_state_t  state_next;
    logic [7:0] rx_upper;
    logic       uart_run;
    logic       uart_clr;
    logic       uart_mode;
    logic       uart_time;
    logic       known;
    logic       ev_runstop;
    logic       ev_clear;
    logic       push;
    logic [7:0] push_data;
    logic       pop;
    logic [7:0] head;
    logic       fifo_full;
    logic       fifo_empty;
    logic       tx_start_q;
    logic [7:0] tx_data_q;

    // Decode the received byte and merge with the button pulses.
    always_comb begin
        rx_upper   = to_upper(uart.rx_data);
        uart_run   = uart.rx_done && (rx_upper == CMD_RUN);
        uart_clr   = uart.rx_done && (rx_upper == CMD_CLR);
        uart_mode  = uart.rx_done && (rx_upper == CMD_MODE);
        uart_time  = uart.rx_done && (rx_upper == CMD_TIME);
        known      = uart_run || uart_clr || uart_mode || uart_time;
        ev_runstop = btn_runstop || uart_run;
        ev_clear   = btn_clear || uart_clr;
        push       = uart.rx_done && (known || ECHO_UNKNOWN);
        push_data  = known ? rx_upper : ACK_UNK;
    end

    // Next-state logic; run/stop takes priority over clear in STOP.
    always_comb begin
        state_next = state_q;
        case (state_q)
            ST_STOP: begin
                if (ev_runstop)
                    state_next = ST_RUN;
                else if (ev_clear)
                    state_next = ST_CLEAR;
            end
            ST_RUN: begin
                if (ev_runstop)
                    state_next = ST_STOP;
            end
            ST_CLEAR: state_next = ST_STOP;
            default:  state_next = ST_STOP;
        endcase
    end

    // State register and registered FSM/toggle outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_STOP;
            run         <= 1'b0;
            clear       <= 1'b0;
            mode_toggle <= 1'b0;
            time_toggle <= 1'b0;
        end else begin
            state_q     <= state_next;
            run         <= (state_next == ST_RUN);
            clear       <= (state_next == ST_CLEAR);
            mode_toggle <= uart_mode;
            time_toggle <= uart_time;
        end
    end

    // Launch only after an idle cycle so tx_busy has time to rise after a start.
    assign pop = !fifo_empty && !uart.tx_busy && !tx_start_q;

    ack_fifo #(
        .WIDTH (8),
        .DEPTH (ACK_DEPTH)
    ) u_ack_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // TX launcher and sticky overflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
            ack_ovf    <= 1'b0;
        end else begin
            tx_start_q <= pop;
            if (pop)
                tx_data_q <= head;
            if (push && fifo_full && !pop)
                ack_ovf <= 1'b1;
        end
    end

    assign uart.tx_start = tx_start_q;
    assign uart.tx_data  = tx_data_q;
    assign state         = state_q;

endmodule

// File: tb/tb_stopwatch_cmd_ctrl.sv
// Directed bench for stopwatch_cmd_ctrl with hand-computed expectations.
module tb_stopwatch_cmd_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic btn_runstop;
    logic btn_clear;
    logic run;
    logic clear;
    logic mode_toggle;
    logic time_toggle;
    logic [1:0] state;
    logic ack_ovf;

    int n_checks = 0;
    int n_pass   = 0;

    stopwatch_cmd_ctrl_if bus ();

    stopwatch_cmd_ctrl #(
        .ACK_DEPTH    (4),
        .ECHO_UNKNOWN (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_runstop (btn_runstop),
        .btn_clear   (btn_clear),
        .uart        (bus),
        .run         (run),
        .clear       (clear),
        .mode_toggle (mode_toggle),
        .time_toggle (time_toggle),
        .state       (state),
        .ack_ovf     (ack_ovf)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_rx(input logic [7:0] b);
        bus.rx_data = b;
        bus.rx_done = 1'b1;
        tick();
        bus.rx_done = 1'b0;
    endtask

    task automatic pulse_runstop();
        btn_runstop = 1'b1;
        tick();
        btn_runstop = 1'b0;
    endtask

    int  n_starts;
    int  n_consec;
    logic prev_start;

    initial begin
        rst          = 1'b1;
        btn_runstop  = 1'b0;
        btn_clear    = 1'b0;
        bus.rx_data  = 8'h00;
        bus.rx_done  = 1'b0;
        bus.tx_busy  = 1'b0;
        tick();
        tick();
        check_val("rst_state",   state,        0);
        check_val("rst_run",     run,          0);
        check_val("rst_clear",   clear,        0);
        check_val("rst_txstart", bus.tx_start, 0);
        check_val("rst_txdata",  bus.tx_data,  0);
        check_val("rst_ovf",     ack_ovf,      0);
        rst = 1'b0;
        tick();

        // Button run/stop toggles RUN and back, never acks.
        pulse_runstop();
        check_val("btn_run_run",   run,   1);
        check_val("btn_run_state", state, 1);
        tick();
        check_val("btn_run_noack", bus.tx_start, 0);
        pulse_runstop();
        check_val("btn_stop_run",   run,   0);
        check_val("btn_stop_state", state, 0);
        tick();
        check_val("btn_stop_noack", bus.tx_start, 0);

        // Lowercase 'c' in STOP: one-cycle clear, ack 'C'.
        send_rx(8'h63);
        check_val("c_clear1",  clear,        1);
        check_val("c_state2",  state,        2);
        check_val("c_nostart", bus.tx_start, 0);
        tick();
        check_val("c_clear0",  clear,        0);
        check_val("c_state0",  state,        0);
        check_val("c_start",   bus.tx_start, 1);
        check_val("c_data",    bus.tx_data,  8'h43);
        tick();
        check_val("c_start_lo", bus.tx_start, 0);
        check_val("c_data_hold", bus.tx_data, 8'h43);

        // 'c' then 'R' while in CLEAR: run request dropped, both still acked.
        send_rx(8'h63);
        send_rx(8'h52);
        check_val("inclr_state", state,        0);
        check_val("inclr_run",   run,          0);
        check_val("inclr_st1",   bus.tx_start, 1);
        check_val("inclr_d1",    bus.tx_data,  8'h43);
        tick();
        check_val("inclr_gap",   bus.tx_start, 0);
        tick();
        check_val("inclr_st2",   bus.tx_start, 1);
        check_val("inclr_d2",    bus.tx_data,  8'h52);
        tick();

        // 'C' while RUN: no clear pulse, ack still sent.
        pulse_runstop();
        send_rx(8'h43);
        check_val("runC_clear", clear, 0);
        check_val("runC_run",   run,   1);
        check_val("runC_state", state, 1);
        tick();
        check_val("runC_start", bus.tx_start, 1);
        check_val("runC_data",  bus.tx_data,  8'h43);
        check_val("runC_run2",  run,          1);
        pulse_runstop();
        check_val("runC_stop",  state, 0);

        // Both buttons in STOP: run/stop wins.
        btn_runstop = 1'b1;
        btn_clear   = 1'b1;
        tick();
        btn_runstop = 1'b0;
        btn_clear   = 1'b0;
        check_val("both_run",   run,   1);
        check_val("both_clear", clear, 0);
        check_val("both_state", state, 1);
        pulse_runstop();
        check_val("both_stop",  state, 0);

        // 'm','T','x' back to back with TX held busy.
        bus.tx_busy = 1'b1;
        send_rx(8'h6D);
        check_val("m_mode", mode_toggle, 1);
        check_val("m_time", time_toggle, 0);
        send_rx(8'h54);
        check_val("t_mode", mode_toggle, 0);
        check_val("t_time", time_toggle, 1);
        send_rx(8'h78);
        check_val("x_mode",  mode_toggle, 0);
        check_val("x_time",  time_toggle, 0);
        check_val("x_state", state,       0);
        tick();
        check_val("busy_nostart", bus.tx_start, 0);
        bus.tx_busy = 1'b0;
        tick();
        check_val("mtx_st1", bus.tx_start, 1);
        check_val("mtx_d1",  bus.tx_data,  8'h4D);
        tick();
        check_val("mtx_gap1", bus.tx_start, 0);
        tick();
        check_val("mtx_st2", bus.tx_start, 1);
        check_val("mtx_d2",  bus.tx_data,  8'h54);
        tick();
        check_val("mtx_gap2", bus.tx_start, 0);
        tick();
        check_val("mtx_st3", bus.tx_start, 1);
        check_val("mtx_d3",  bus.tx_data,  8'h3F);
        tick();
        tick();
        check_val("mtx_empty", bus.tx_start, 0);
        check_val("mtx_hold",  bus.tx_data,  8'h3F);

        // Six bytes into a four-deep queue while busy.
        bus.tx_busy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send_rx(8'h4D);
            if (i == 3)
                check_val("ovf_at4", ack_ovf, 0);
            if (i == 4)
                check_val("ovf_at5", ack_ovf, 1);
        end
        bus.tx_busy = 1'b0;
        n_starts   = 0;
        n_consec   = 0;
        prev_start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.tx_start) begin
                n_starts++;
                if (prev_start)
                    n_consec++;
            end
            prev_start = bus.tx_start;
        end
        check_val("ovf_queued", n_starts, 4);
        check_val("ovf_consec", n_consec, 0);
        check_val("ovf_sticky", ack_ovf,  1);

        // Reset mid-operation empties the queue and clears the flag.
        bus.tx_busy = 1'b1;
        send_rx(8'h54);
        send_rx(8'h54);
        pulse_runstop();
        rst = 1'b1;
        tick();
        check_val("rst2_ovf",   ack_ovf,     0);
        check_val("rst2_state", state,       0);
        check_val("rst2_run",   run,         0);
        check_val("rst2_data",  bus.tx_data, 0);
        rst = 1'b0;
        bus.tx_busy = 1'b0;
        n_starts = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.tx_start)
                n_starts++;
        end
        check_val("rst2_empty", n_starts, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
